// File: rtl/arith_ext_share.sv
// arith_ext_share
//   Shares one zero/sign width-extension datapath among NUM_IN requester
//   channels. A round-robin arbiter picks one valid requester per cycle, its
//   IN_WIDTH operand is extended to OUT_WIDTH and captured in a registered
//   output stage together with the winning channel index as a tag.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      per-channel operand valid
//   in_ready      per-channel accept, one-hot or zero
//   in_data       flattened operands, channel i at [i*IN_WIDTH +: IN_WIDTH]
//   in_sext       per-channel mode, 1 = sign-extend, 0 = zero-extend
//   result_valid  output register holds a result
//   result_ready  consumer accepts the result
//   result_data   extended operand
//   result_tag    channel that produced result_data
//
// Build option
//   ARITH_EXT_SHARE_SEXT_EN  defined: in_sext selects sign/zero extension.
//                            undefined: in_sext is ignored, always zero-extend.

module arith_ext_share #(
    parameter int NUM_IN    = 4,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TAG_WIDTH = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [NUM_IN*IN_WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]            in_sext,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [OUT_WIDTH-1:0]         result_data,
    output logic [TAG_WIDTH-1:0]         result_tag
);

    logic                 load_en;
    logic                 win_found;
    logic [TAG_WIDTH-1:0] win_idx;
    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [IN_WIDTH-1:0]  ch_data [NUM_IN];
    logic [IN_WIDTH-1:0]  operand;
    logic                 sext_sel;
    logic [OUT_WIDTH-1:0] ext_data;

    // Output register can take a new value when empty or being drained.
    assign load_en = !result_valid || result_ready;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*IN_WIDTH +: IN_WIDTH];
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_IN so that
    // non-power-of-two channel counts never address a missing channel.
    always_comb begin
        int                   idx;
        logic [TAG_WIDTH-1:0] sel;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            sel = TAG_WIDTH'(idx);
            if (!win_found && in_valid[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    // Nothing is accepted in the reset cycle, even though the arbiter is live.
    always_comb begin
        in_ready = '0;
        if (!rst && win_found && load_en) begin
            in_ready[win_idx] = 1'b1;
        end
    end

    assign operand = ch_data[win_idx];

`ifdef ARITH_EXT_SHARE_SEXT_EN
    assign sext_sel = in_sext[win_idx];
`else
    logic unused_sext;
    assign unused_sext = ^in_sext;
    assign sext_sel    = 1'b0;
`endif

    if (OUT_WIDTH > IN_WIDTH) begin : g_ext
        assign ext_data = {{(OUT_WIDTH-IN_WIDTH){sext_sel & operand[IN_WIDTH-1]}}, operand};
    end else begin : g_pass
        assign ext_data = operand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0;
            result_data  <= '0;
            result_tag   <= '0;
            rr_ptr       <= '0;
        end else if (load_en) begin
            if (win_found) begin
                result_valid <= 1'b1;
                result_data  <= ext_data;
                result_tag   <= win_idx;
                if (win_idx == TAG_WIDTH'(NUM_IN-1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= win_idx + 1'b1;
                end
            end else begin
                // Drain without refill: data and tag keep their last values.
                result_valid <= 1'b0;
            end
        end
    end

endmodule
